// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces the coin sensor, buffers accepted coins in a 4-entry FIFO and
// issues at most one coin every two cycles. Define COIN_ACCEPTOR_COUNT_EN for the issued-coin counter.

module coin_acceptor #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_in,
    input  logic [1:0] den,
    input  logic       hold,
    output logic [1:0] d,
    output logic       coin_rej,
    output logic       fifo_full,
    output logic [7:0] coin_cnt
);

    localparam int         DEPTH    = 4;
    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WAIT_REL
    } deb_state_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_GAP
    } out_state_t;

    deb_state_t deb_state, deb_state_nxt;
    out_state_t out_state, out_state_nxt;

    logic [1:0] den_q, den_q_nxt;
    logic [3:0] deb_cnt, deb_cnt_nxt;
    logic       coin_rej_nxt;
    logic [1:0] d_nxt;

    logic       push;
    logic       pop;
    logic [1:0] fifo_mem [DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fill;
    logic       fifo_empty;

    assign fifo_full  = (fill == 3'(DEPTH));
    assign fifo_empty = (fill == 3'd0);

    // Debounce FSM: next state, accept/reject decision and push request.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        deb_state_nxt = deb_state;
        den_q_nxt     = den_q;
        deb_cnt_nxt   = deb_cnt;
        coin_rej_nxt  = 1'b0;
        push          = 1'b0;

        case (deb_state)
            IDLE: begin
                if (coin_in) begin
                    deb_state_nxt = CHECK;
                    den_q_nxt     = den;
                    deb_cnt_nxt   = 4'd1;
                end
            end
            CHECK: begin
                if (!coin_in) begin
                    deb_state_nxt = IDLE;
                end else if (den != den_q) begin
                    coin_rej_nxt  = 1'b1;
                    deb_state_nxt = WAIT_REL;
                end else if (deb_cnt == DEB_LAST) begin
                    deb_state_nxt = WAIT_REL;
                    // Fullness comes from the registered fill, i.e. before any same-cycle pop.
                    if (den_q == 2'b00 || fifo_full) begin
                        coin_rej_nxt = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else begin
                    deb_cnt_nxt = deb_cnt + 4'd1;
                end
            end
            WAIT_REL: begin
                if (!coin_in) begin
                    deb_state_nxt = IDLE;
                end
            end
            default: begin
                deb_state_nxt = IDLE;
            end
        endcase
    end

    // Output FSM: one coin, then a mandatory 00 gap cycle.
    always_comb begin
        out_state_nxt = out_state;
        pop           = 1'b0;
        d_nxt         = 2'b00;

        case (out_state)
            OUT_IDLE: begin
                if (!fifo_empty && !hold) begin
                    pop           = 1'b1;
                    d_nxt         = fifo_mem[rd_ptr];
                    out_state_nxt = OUT_GAP;
                end
            end
            OUT_GAP: begin
                out_state_nxt = OUT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
        if (rst) begin
            deb_state <= IDLE;
            out_state <= OUT_IDLE;
            den_q     <= 2'b00;
            deb_cnt   <= 4'd0;
            coin_rej  <= 1'b0;
            d         <= 2'b00;
        end else begin
            deb_state <= deb_state_nxt;
            out_state <= out_state_nxt;
            den_q     <= den_q_nxt;
            deb_cnt   <= deb_cnt_nxt;
            coin_rej  <= coin_rej_nxt;
            d         <= d_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            fill   <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 3'd1;
                2'b01:   fill <= fill - 3'd1;
                default: fill <= fill;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and fill count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= den_q;
        end
    end

`ifdef COIN_ACCEPTOR_COUNT_EN
    logic [7:0] issued_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt <= 8'd0;
        end else if (pop && issued_cnt != 8'hFF) begin
            issued_cnt <= issued_cnt + 8'd1;
        end
    end

    assign coin_cnt = issued_cnt;
`else
    assign coin_cnt = 8'h00;
`endif

endmodule
